// File: rtl/regfile_sb.sv
// regfile_sb: parametrised general-purpose register file with a hard-wired zero register,
// same-cycle write bypass, a pending-write scoreboard and a multi-cycle clear sequencer.
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rg_wrt_en,
  input  logic [ADDR_W-1:0] rg_wrt_addr,
  input  logic [DATA_W-1:0] rg_wrt_data,
  input  logic [ADDR_W-1:0] rg_rd_addr1,
  input  logic [ADDR_W-1:0] rg_rd_addr2,
  output logic [DATA_W-1:0] rg_rd_data1,
  output logic [DATA_W-1:0] rg_rd_data2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              rg_busy1,
  output logic              rg_busy2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   idx_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DEPTH-1:0]    pend_r;
  logic                idle_s;
  logic                wr_ok_s;
  logic                iss_ok_s;
  logic [ADDR_W-1:0]   rd_addr_s [2];
  logic [DATA_W-1:0]   rd_data_s [2];
  logic [1:0]          rd_busy_s;

  // Writes and reservations are honoured only in IDLE; address 0 is dropped when hard-wired.
  always_comb begin
    idle_s   = (state_r == ST_IDLE);
    wr_ok_s  = idle_s && rg_wrt_en && !(ZERO_R0 && (rg_wrt_addr == {ADDR_W{1'b0}}));
    iss_ok_s = idle_s && issue_en  && !(ZERO_R0 && (issue_addr  == {ADDR_W{1'b0}}));
  end

  // Clear sequencer next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) state_s = ST_CLEAR;
        else         state_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (idx_r == {ADDR_W{1'b1}}) state_s = ST_DONE;
        else                         state_s = ST_CLEAR;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and clear index; the index wraps to 0 naturally after the last entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_r == ST_CLEAR) idx_r <= idx_r + ADDR_W'(1'b1);
      else                     idx_r <= {ADDR_W{1'b0}};
    end
  end

  // Register array: reset and the clear sweep take priority over writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      mem_r[idx_r] <= {DATA_W{1'b0}};
    end else if (wr_ok_s) begin
      mem_r[rg_wrt_addr] <= rg_wrt_data;
    end
  end

  // Pending scoreboard: a new reservation overrides a same-cycle completing write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r <= {DEPTH{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      pend_r[idx_r] <= 1'b0;
    end else begin
      if (wr_ok_s)  pend_r[rg_wrt_addr] <= 1'b0;
      if (iss_ok_s) pend_r[issue_addr]  <= 1'b1;
    end
  end

  assign rd_addr_s[0] = rg_rd_addr1;
  assign rd_addr_s[1] = rg_rd_addr2;

  // Read ports: zero register, then forwarded write, then array contents.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = mem_r[rd_addr_s[p]];
      rd_busy_s[p] = pend_r[rd_addr_s[p]];
      if (ZERO_R0 && (rd_addr_s[p] == {ADDR_W{1'b0}})) begin
        rd_data_s[p] = {DATA_W{1'b0}};
        rd_busy_s[p] = 1'b0;
      end else if (BYPASS && wr_ok_s && (rg_wrt_addr == rd_addr_s[p])) begin
        rd_data_s[p] = rg_wrt_data;
        rd_busy_s[p] = 1'b0;
      end else begin
        rd_data_s[p] = mem_r[rd_addr_s[p]];
        rd_busy_s[p] = pend_r[rd_addr_s[p]];
      end
    end
  end

  assign rg_rd_data1 = rd_data_s[0];
  assign rg_rd_data2 = rd_data_s[1];
  assign rg_busy1    = rd_busy_s[0];
  assign rg_busy2    = rd_busy_s[1];
  assign clr_busy    = (state_r != ST_IDLE);
  assign clr_done    = (state_r == ST_DONE);

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the RISC-V core, with configurable data width and depth, hard-wired zero register, same-cycle write-to-read bypass, a per-register pending-write scoreboard for pipeline hazard detection, and a multi-cycle clear sequencer. It sits between decode (read ports, issue reservation) and writeback (write port). It replaces the fixed 32x32 two-read-port register file in the datapath.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W registers
- ZERO_R0, 1, 1: register 0 reads as 0, ignores writes, is never pending
- BYPASS, 1, 1: a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rg_wrt_en  in  1  writeback write enable
- rg_wrt_addr  in  ADDR_W  write address
- rg_wrt_data  in  DATA_W  write data
- rg_rd_addr1, rg_rd_addr2  in  ADDR_W  read addresses
- rg_rd_data1, rg_rd_data2  out  DATA_W  read data, combinational
- issue_en  in  1  reserve destination register (set pending)
- issue_addr  in  ADDR_W  destination being reserved
- rg_busy1, rg_busy2  out  1  read address has an unresolved pending write
- clr_req  in  1  start clear sequence (single-cycle pulse, sampled in IDLE only)
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse when clear completes

## Operation
- Storage: DEPTH x DATA_W array `mem`, plus DEPTH-bit `pend` vector, 2-bit FSM state, ADDR_W-bit clear index `idx`.
- Reset (synchronous, dominates all inputs): every `mem` entry = 0, `pend` = 0, state = IDLE, `idx` = 0. Outputs after reset: read data 0, rg_busy* 0, clr_busy 0, clr_done 0.
- Write: in IDLE, rg_wrt_en=1 writes `mem[rg_wrt_addr]` and clears `pend[rg_wrt_addr]` at the clock edge. With ZERO_R0, address 0 is ignored.
- Issue: in IDLE, issue_en=1 sets `pend[issue_addr]`. With ZERO_R0, address 0 is ignored. If issue and write target the same address in one cycle, set wins (new producer supersedes).
- Read: rg_rd_dataN = `mem[rg_rd_addrN]`. With ZERO_R0 and address 0, the port returns 0. With BYPASS, in IDLE, when rg_wrt_en=1 and rg_wrt_addr==rg_rd_addrN (not suppressed address 0), the port returns rg_wrt_data.
- Busy: rg_busyN = `pend[rg_rd_addrN]`. With BYPASS, it is forced 0 when a matching write is forwarded that cycle. It is always 0 for address 0 when ZERO_R0.
- Clear FSM:
  - IDLE: clr_req=1 moves to CLEAR with idx=0.
  - CLEAR: each cycle, `mem[idx]`=0 and `pend[idx]`=0, then idx+1. At idx==DEPTH-1, move to DONE and wrap idx to 0.
  - DONE: clr_done=1 for one cycle, then move to IDLE.
  - clr_busy=1 in CLEAR and DONE.
  - While not IDLE: rg_wrt_en, issue_en and clr_req are ignored (dropped, not queued). Bypass is disabled. Reads return current array contents, so registers not yet cleared still show their old values.
- reset asserted mid-clear: the block returns to IDLE the next edge with everything zeroed. No clr_done pulse is produced.

## Timing
- Read latency 0 (combinational from address). A write is visible from the array on the cycle after its edge, or in the same cycle through bypass.
- Pending bit is visible on rg_busy the cycle after issue_en.
- Clear: clr_req sampled at edge T. CLEAR occupies cycles T+1..T+DEPTH. DONE (clr_done=1) is cycle T+DEPTH+1. IDLE resumes at T+DEPTH+2.
- With DEPTH=32, clr_busy stays high for 33 cycles.

## Test plan
- Reset then read all addresses -> all data 0, rg_busy1/2=0, clr_busy=0.
- Write 0xDEADBEEF to x5 with rg_rd_addr1=5 in the same cycle -> BYPASS=1: rg_rd_data1=0xDEADBEEF that cycle; BYPASS=0: old value, then 0xDEADBEEF the next cycle.
- Write 0x1234 to x0, then read x0 -> 0 (ZERO_R0=1); issue_en to x0 -> rg_busy1 stays 0.
- issue_en x7; next cycle rg_rd_addr1=7 -> rg_busy1=1. Write x7=0x55 -> rg_busy1=0 (bypass) and data 0x55. Simultaneous issue+write x7 -> pending stays 1.
- Fill x1..x31 with nonzero values, pulse clr_req -> clr_busy high for 33 cycles, clr_done at cycle 33, all reads 0 afterwards. A write to x3 during CLEAR is dropped.
- Assert reset at cycle 10 of a clear -> next cycle: IDLE, clr_busy=0, all registers 0, no clr_done pulse.
